gb_conv_arbiter: RTL

- Shares one Gray-to-binary converter among N_REQ requesters.
- Each requester presents a Gray code with a valid/ready handshake. A round-robin arbiter grants one requester per cycle.
- The converted binary value and the granted requester's ID are registered into a single-entry output stage with its own valid/ready handshake.
- The block sits between Gray-coded sources (counters, encoders, pointer-crossing logic) and binary consumers.

---
 rtl/gb_conv_arbiter_pkg.sv | 22 ++
 rtl/gb_conv_arbiter_gray2bin.sv | 17 +
 rtl/gb_conv_arbiter.sv | 88 ++++++++
 3 files changed

// File: rtl/gb_conv_arbiter_pkg.sv
// Shared defaults and helpers for the Gray-to-binary arbiter.
// Build option GB_CONV_ARB_CNT_EN adds a conversion counter.
package gb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 4;

  function automatic int id_width(input int n);
    int c;
    c = $clog2(n);
    return (c < 1) ? 1 : c;
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gb_conv_arbiter_gray2bin.sv
// W-bit combinational Gray-to-binary converter.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_w #(
  parameter int W = 4
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);

  // Prefix XOR from the MSB down
  always_comb begin
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
  end

endmodule

// File: rtl/gb_conv_arbiter.sv
// Round-robin shared Gray-to-binary converter with one output register.
// Define GB_CONV_ARB_CNT_EN to add the saturating conv_count port.
module gb_conv_arbiter
  import gb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  localparam int IDW  = id_width(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_gray,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       out_bin,
`ifdef GB_CONV_ARB_CNT_EN
  output logic [15:0]        conv_count,
`endif
  output logic [IDW-1:0]     out_id
);

  logic [IDW-1:0]   last_id;
  logic [IDW-1:0]   gnt_id;
  logic [N_REQ-1:0] grant;
  logic             found;
  logic             can_accept;
  logic             take;
  logic [W-1:0]     sel_gray;
  logic [W-1:0]     sel_bin;
  int               idx;

  assign can_accept = !out_valid | out_ready;

  // Search from last_id+1 upward, wrapping, for the first valid requester
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_id) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gnt_id     = IDW'(idx);
      end
    end
  end

  assign req_ready = can_accept ? grant : '0;
  assign take      = can_accept & found;
  assign sel_gray  = req_gray[int'(gnt_id)*W +: W];

  gray2bin_w #(.W(W)) u_conv (
    .g (sel_gray),
    .b (sel_bin)
  );

  // Output register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_id    <= '0;
      last_id   <= IDW'(N_REQ - 1);
    end else if (take) begin
      out_valid <= 1'b1;
      out_bin   <= sel_bin;
      out_id    <= gnt_id;
      last_id   <= gnt_id;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef GB_CONV_ARB_CNT_EN
  // Count delivered results, sticking at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conv_count <= '0;
    else if (out_valid && out_ready && conv_count != 16'hFFFF)
      conv_count <= conv_count + 16'd1;
  end
`endif

endmodule
